apb_initiator: RTL and testbench
================================

APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 SHALL have parameter addrWidth, default 8, APB address width.
REQ-002 SHALL have parameter dataWidth, default 91, APB write/read data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, max ACCESS cycles waiting for pready (legal range 2..255).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port cmd_valid  input  1  command request.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-008 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port cmd_addr  input  addrWidth  target register address.
REQ-010 SHALL have port cmd_wdata  input  dataWidth  write data.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-013 SHALL have port rsp_rdata  output  dataWidth  read data, 0 for writes and timeouts.
REQ-014 SHALL have port rsp_timeout  output  1  transfer aborted, pready never seen.
REQ-015 SHALL have ports paddr (addrWidth), pwrite (1), psel (1), penable (1), pwdata (dataWidth)  output  APB requester signals, all registered.
REQ-016 SHALL have ports prdata (dataWidth), pready (1)  input  APB completer signals.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-018 cmd_ready SHALL be 1 exactly when state is IDLE, decoded combinationally from state.
REQ-019 IDLE: on an edge with cmd_valid=1, SHALL latch cmd_write/cmd_addr/cmd_wdata into paddr/pwrite/pwdata, set psel=1, penable=0, and go to SETUP.
REQ-020 SETUP SHALL last exactly one cycle, then set penable=1 and go to ACCESS; pready is ignored in SETUP.
REQ-021 paddr, pwrite, pwdata SHALL stay stable from SETUP through the last ACCESS cycle.
REQ-022 ACCESS: on an edge with pready=1, SHALL capture prdata into rsp_rdata if pwrite=0 (else rsp_rdata=0), set rsp_timeout=0, clear psel/penable, set rsp_valid=1, and go to RESP.
REQ-023 ACCESS SHALL count consecutive cycles with pready=0 using a counter cleared on entry to SETUP. If pready is still 0 on the TIMEOUT-th ACCESS cycle, SHALL clear psel/penable, set rsp_rdata=0, rsp_timeout=1, rsp_valid=1, and go to RESP.
REQ-024 pready=1 on the TIMEOUT-th ACCESS cycle SHALL count as normal completion, with timeout=0.
REQ-025 RESP: rsp_valid, rsp_rdata, rsp_timeout SHALL hold until an edge with rsp_ready=1, which clears rsp_valid and returns to IDLE. psel SHALL stay 0 in RESP.
REQ-026 Minimum transfer timing: accept edge N; SETUP cycle N+1; ACCESS cycle N+2; rsp_valid high cycle N+3; cmd_ready high again cycle N+4 when rsp_ready=1 at the end of N+3. Back-to-back throughput is one command per 4 cycles.
REQ-027 In IDLE and RESP, paddr/pwdata/pwrite SHALL retain the last transfer's values, and psel=penable=0.
REQ-028 A new command SHALL never be accepted while rsp_valid=1; cmd_valid outside IDLE has no effect.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, and wait counter=0.
REQ-030 Reset during SETUP/ACCESS/RESP SHALL discard the in-flight command with no response produced. After rst_n rises, the first command SHALL be accepted on the first edge with cmd_valid=1.

Verification
REQ-031 Write addr 5 data 1, pready=1 tied: psel rises N+1, penable N+2, rsp_valid N+3 with rdata=0 and timeout=0.
REQ-032 Read addr 5 with completer returning prdata=1 and pready=1: rsp_rdata=1 at N+3, and pwrite=0 throughout SETUP/ACCESS.
REQ-033 Write addr 2 data 10 with pready low for 3 ACCESS cycles then high: paddr=2 and pwdata=10 stable for 5 cycles, rsp_valid at N+6, timeout=0.
REQ-034 Read addr 7 with pready held 0: after 16 ACCESS cycles psel=penable=0, rsp_valid=1, rsp_timeout=1, rsp_rdata=0.
REQ-035 rsp_ready held 0 for 5 cycles with cmd_valid=1: rsp_valid and data hold, cmd_ready=0, psel stays 0. rsp_ready=1 returns to IDLE, and the next command is accepted the following edge.
REQ-036 rst_n pulsed low during ACCESS of write addr 5 data 15: psel/penable drop immediately without waiting for a clock, no rsp_valid appears, and a fresh read addr 5 then completes normally.

Source files
------------

// File: rtl/apb_initiator.sv
// -----------------------------------------------------------------------------
// apb_initiator
//   Turns a simple valid/ready command into one APB transfer and returns the
//   result on a valid/ready response channel. Only one transfer is ever in
//   flight. A transfer whose completer never raises pready within TIMEOUT
//   ACCESS cycles is abandoned and reported with rsp_timeout=1.
//
// Parameters
//   addrWidth  APB address width
//   dataWidth  APB read/write data width
//   TIMEOUT    ACCESS cycles allowed before the transfer is abandoned (2..255)
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_ready is high only in IDLE
//   cmd_write/addr/wdata       command payload (1 = write)
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata, rsp_timeout     read data (0 for writes and timeouts), abort flag
//   paddr/pwrite/psel/penable/pwdata   APB requester outputs, all registered
//   prdata, pready             APB completer inputs
// -----------------------------------------------------------------------------
module apb_initiator #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 91,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [dataWidth-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic                 rsp_timeout,
  output logic [addrWidth-1:0] paddr,
  output logic                 pwrite,
  output logic                 psel,
  output logic                 penable,
  output logic [dataWidth-1:0] pwdata,
  input  logic [dataWidth-1:0] prdata,
  input  logic                 pready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Value of the wait counter on the last ACCESS cycle a transfer may use.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t                 state_q,       state_d;
  logic [addrWidth-1:0]   paddr_q,       paddr_d;
  logic                   pwrite_q,      pwrite_d;
  logic [dataWidth-1:0]   pwdata_q,      pwdata_d;
  logic                   psel_q,        psel_d;
  logic                   penable_q,     penable_d;
  logic                   rsp_valid_q,   rsp_valid_d;
  logic [dataWidth-1:0]   rsp_rdata_q,   rsp_rdata_d;
  logic                   rsp_timeout_q, rsp_timeout_d;
  logic [7:0]             wait_cnt_q,    wait_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_cnt_d    = wait_cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d    = cmd_addr;
          pwrite_d   = cmd_write;
          pwdata_d   = cmd_wdata;
          psel_d     = 1'b1;
          penable_d  = 1'b0;
          wait_cnt_d = '0;
          state_d    = SETUP;
        end
      end

      // pready is deliberately not looked at here: SETUP is always one cycle.
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        if (pready) begin
          // Completion wins even on the last allowed cycle.
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = RESP;
        end else if (wait_cnt_q == LAST_WAIT) begin
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwdata      = pwdata_q;

endmodule

// File: tb/tb_apb_initiator.sv
// -----------------------------------------------------------------------------
// tb_apb_initiator
//   Directed vectors for apb_initiator. Stimulus pushes the expected response
//   (data, timeout flag, cycle it must appear) into a scoreboard queue; a
//   monitor pops and compares when rsp_valid rises and checks the held
//   response afterwards. A completer model drives pready/prdata and checks
//   the APB requester signals on every selected cycle.
// -----------------------------------------------------------------------------
module tb_apb_initiator;

  localparam int AW = 8;
  localparam int DW = 91;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_timeout;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;

  apb_initiator #(.addrWidth(AW), .dataWidth(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          to;
    int            at;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Completer configuration and expected APB payload for the current transfer.
  int            comp_wait  = 0;
  logic [DW-1:0] comp_rdata = '0;
  logic [AW-1:0] exp_addr   = '0;
  logic          exp_write  = 1'b0;
  logic [DW-1:0] exp_wdata  = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // ---------------- completer model ----------------
  int acc_cnt  = 0;
  int sel_seen = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || !psel) begin
        acc_cnt  = 0;
        sel_seen = 0;
        pready   = 1'b0;
      end else begin
        n_vec++;
        if (paddr !== exp_addr || pwrite !== exp_write || pwdata !== exp_wdata ||
            penable !== (sel_seen != 0)) begin
          n_miss++;
          $display("FAIL apb_bus: got addr=%0h wr=%0b wdata=%0h en=%0b want addr=%0h wr=%0b wdata=%0h en=%0b",
                   paddr, pwrite, pwdata, penable, exp_addr, exp_write, exp_wdata, (sel_seen != 0));
        end
        pready = (acc_cnt >= comp_wait);
        prdata = comp_rdata;
        if (penable) acc_cnt++;
        sel_seen++;
      end
    end
  end

  // ---------------- response monitor ----------------
  bit            mon_pv = 1'b0;
  logic [DW-1:0] mon_sd = '0;
  logic          mon_st = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_pv = 1'b0;
      end else begin
        if (rsp_valid && !mon_pv) begin
          n_vec++;
          if (sb.size() == 0) begin
            n_miss++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 want no response (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            if (rsp_rdata !== e.rdata || rsp_timeout !== e.to || cyc != e.at) begin
              n_miss++;
              $display("FAIL rsp: got rdata=%0h to=%0b cycle=%0d want rdata=%0h to=%0b cycle=%0d",
                       rsp_rdata, rsp_timeout, cyc, e.rdata, e.to, e.at);
            end
            $display("rsp: rdata=%0h timeout=%0b cycle=%0d", rsp_rdata, rsp_timeout, cyc);
          end
          mon_sd = rsp_rdata;
          mon_st = rsp_timeout;
        end else if (rsp_valid) begin
          n_vec++;
          if (rsp_rdata !== mon_sd || rsp_timeout !== mon_st) begin
            n_miss++;
            $display("FAIL rsp_hold: got rdata=%0h to=%0b want rdata=%0h to=%0b",
                     rsp_rdata, rsp_timeout, mon_sd, mon_st);
          end
        end
        if (rsp_valid) begin
          n_vec++;
          if (psel !== 1'b0 || penable !== 1'b0 || cmd_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL resp_state: got psel=%0b penable=%0b cmd_ready=%0b want 0 0 0",
                     psel, penable, cmd_ready);
          end
        end
        mon_pv = rsp_valid;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((sb.size() != 0 || rsp_valid) && k < 200);
    if (sb.size() != 0 || rsp_valid) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: got pending=%0d want 0", sb.size());
    end
  endtask

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW-1:0] pd, input int waits, input logic [DW-1:0] er,
                       input logic et, input int lat, input bit push);
    int   k;
    exp_t e;
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_wait", {{(DW-1){1'b0}}, cmd_ready}, 1);
      return;
    end
    comp_wait  = waits;
    comp_rdata = pd;
    exp_addr   = a;
    exp_write  = w;
    exp_wdata  = wd;
    cmd_valid  = 1'b1;
    cmd_write  = w;
    cmd_addr   = a;
    cmd_wdata  = wd;
    @(negedge clk);
    // Scramble the command bus: the APB side must hold the latched copy.
    cmd_valid = 1'b0;
    cmd_write = ~w;
    cmd_addr  = ~a;
    cmd_wdata = ~wd;
    $display("cmd: write=%0b addr=%0h wdata=%0h accepted at edge %0d", w, a, wd, cyc);
    chk("accepted", {{(DW-1){1'b0}}, cmd_ready}, 0);
    e.rdata = er;
    e.to    = et;
    e.at    = cyc + lat;
    if (push) begin
      sb.push_back(e);
      wait_idle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000");
    $fatal(1, "watchdog expired");
  end

  localparam logic [DW-1:0] PAT = 91'h2AB_CDEF_0123_4567_89AB_CDEF;

  initial begin
    exp_t e;
    int   k;
    int   rel;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_psel",    {{(DW-1){1'b0}}, psel},        0);
    chk("rst_penable", {{(DW-1){1'b0}}, penable},     0);
    chk("rst_pwrite",  {{(DW-1){1'b0}}, pwrite},      0);
    chk("rst_paddr",   {{(DW-AW){1'b0}}, paddr},      0);
    chk("rst_pwdata",  pwdata,                        0);
    chk("rst_rvalid",  {{(DW-1){1'b0}}, rsp_valid},   0);
    chk("rst_rdata",   rsp_rdata,                     0);
    chk("rst_rto",     {{(DW-1){1'b0}}, rsp_timeout}, 0);
    chk("rst_cready",  {{(DW-1){1'b0}}, cmd_ready},   1);
    rst_n = 1'b1;

    //     wr    addr   wdata   prdata  waits er     to    lat push
    issue(1'b1, 8'd5,  91'd1,  PAT,    0,    91'd0, 1'b0, 2,  1'b1); // write, pready at once
    issue(1'b0, 8'd5,  91'd0,  91'd1,  0,    91'd1, 1'b0, 2,  1'b1); // read returns 1
    issue(1'b1, 8'd2,  91'd10, PAT,    3,    91'd0, 1'b0, 5,  1'b1); // 3 wait states
    issue(1'b0, 8'd7,  91'd0,  PAT,    99,   91'd0, 1'b1, 17, 1'b1); // timeout
    issue(1'b0, 8'd3,  PAT,    PAT,    15,   PAT,   1'b0, 17, 1'b1); // pready on last cycle
    issue(1'b0, 8'd9,  91'd4,  PAT,    16,   91'd0, 1'b1, 17, 1'b1); // one cycle too late
    issue(1'b1, 8'hFF, ~PAT,   PAT,    1,    91'd0, 1'b0, 3,  1'b1); // write ignores prdata

    // Response back-pressure with a pending command on the bus.
    rsp_ready  = 1'b0;
    comp_wait  = 0;
    comp_rdata = 91'h55;
    exp_addr   = 8'd4;
    exp_write  = 1'b0;
    exp_wdata  = 91'd0;
    chk("bp_ready", {{(DW-1){1'b0}}, cmd_ready}, 1);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'd4;
    cmd_wdata = 91'd0;
    @(negedge clk);
    e.rdata = 91'h55;
    e.to    = 1'b0;
    e.at    = cyc + 2;
    sb.push_back(e);
    cmd_write = 1'b1;
    cmd_addr  = 8'd6;
    cmd_wdata = 91'd3;
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("bp_rsp_seen", {{(DW-1){1'b0}}, rsp_valid}, 1);
    repeat (5) @(negedge clk);
    chk("bp_hold_valid", {{(DW-1){1'b0}}, rsp_valid}, 1);
    chk("bp_hold_data",  rsp_rdata, 91'h55);
    chk("bp_psel",       {{(DW-1){1'b0}}, psel},      0);
    chk("bp_cready",     {{(DW-1){1'b0}}, cmd_ready}, 0);
    rsp_ready = 1'b1;
    rel = cyc;
    @(negedge clk);
    chk("bp_released", {{(DW-1){1'b0}}, rsp_valid}, 0);
    chk("bp_idle",     {{(DW-1){1'b0}}, cmd_ready}, 1);
    exp_addr  = 8'd6;
    exp_write = 1'b1;
    exp_wdata = 91'd3;
    e.rdata   = 91'd0;
    e.to      = 1'b0;
    e.at      = rel + 4;
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_next_accepted", {{(DW-1){1'b0}}, psel}, 1);
    wait_idle();

    // Reset in the middle of an ACCESS phase.
    issue(1'b1, 8'd5, 91'd15, PAT, 1000, 91'd0, 1'b0, 0, 1'b0);
    k = 0;
    while (!penable && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("mid_access", {{(DW-1){1'b0}}, penable}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_psel",    {{(DW-1){1'b0}}, psel},      0);
    chk("async_penable", {{(DW-1){1'b0}}, penable},   0);
    chk("async_cready",  {{(DW-1){1'b0}}, cmd_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_rsp_after_rst", {{(DW-1){1'b0}}, rsp_valid}, 0);
    issue(1'b0, 8'd5, 91'd0, 91'h77, 0, 91'h77, 1'b0, 2, 1'b1);

    repeat (2) @(negedge clk);
    chk("sb_empty", DW'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
